// File: rtl/branch_target_unit.sv
// ---------------------------------------------------------------------------
// branch_target_unit
//
// Purpose:
//   Computes a branch target as program_counter + sign-extended immediate
//   (word addressed, no shift) behind a single valid/ready output register,
//   and optionally hosts a direct-mapped branch target buffer (BTB) for
//   fetch-time prediction.
//
// Configuration:
//   BTU_BTB_EN  - when defined, the BTB (lookup + resolved-branch update) is
//                 built. When undefined, there is no BTB storage, pred_hit and
//                 pred_target are tied to 0 and the update inputs are ignored.
//                 The calculation path is identical in both builds.
//
// Parameters:
//   PC_W       program-counter / target width (>= 4)
//   IMM_W      immediate width (>= 2)
//   BTB_DEPTH  BTB entry count (power of 2, 2..64, log2 < PC_W)
//
// Ports:
//   clk, rst_n        single rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (in_ready = !bt_valid || bt_ready)
//   immediate         signed word offset
//   program_counter   next-instruction PC
//   bt_valid/bt_ready result handshake
//   BT, bt_wrap       registered target and wrap flag
//   lookup_pc         fetch PC; pred_hit/pred_target answer one cycle later
//   upd_*             resolved-branch update of the BTB
// ---------------------------------------------------------------------------
module branch_target_unit #(
  parameter int PC_W      = 8,
  parameter int IMM_W     = 16,
  parameter int BTB_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [PC_W-1:0]   program_counter,
  output logic              bt_valid,
  input  logic              bt_ready,
  output logic [PC_W-1:0]   BT,
  output logic              bt_wrap,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_taken
);

  // Two extra bits beyond the wider operand hold any signed sum of an
  // unsigned PC and a signed immediate without overflow.
  localparam int SUM_W = ((PC_W > IMM_W) ? PC_W : IMM_W) + 2;

  // -------------------------------------------------------------------------
  // Calculation path
  // -------------------------------------------------------------------------
  logic [SUM_W-1:0] pcExt;
  logic [SUM_W-1:0] immExt;
  logic [SUM_W-1:0] sumExt;
  logic             accept;
  logic             btValid_q, btValid_d;
  logic [PC_W-1:0]  btTarget_q, btTarget_d;
  logic             btWrap_q, btWrap_d;

  assign in_ready = !btValid_q || bt_ready;
  assign accept   = in_valid && in_ready;

  // The sum leaves 0..2^PC_W-1 exactly when any bit above PC_W is set:
  // negative results carry a sign bit, large positives carry a high bit.
  always_comb begin
    pcExt      = {{(SUM_W-PC_W){1'b0}}, program_counter};
    immExt     = {{(SUM_W-IMM_W){immediate[IMM_W-1]}}, immediate};
    sumExt     = pcExt + immExt;
    btTarget_d = sumExt[PC_W-1:0];
    btWrap_d   = |sumExt[SUM_W-1:PC_W];
  end

  // Accept takes priority over drain so a simultaneous accept and drain
  // replaces the result while bt_valid stays high.
  always_comb begin
    btValid_d = btValid_q;
    if (accept) begin
      btValid_d = 1'b1;
    end else if (bt_ready) begin
      btValid_d = 1'b0;
    end
  end

  // Data registers load only on accept, so they hold under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btValid_q  <= 1'b0;
      btTarget_q <= '0;
      btWrap_q   <= 1'b0;
    end else begin
      btValid_q <= btValid_d;
      if (accept) begin
        btTarget_q <= btTarget_d;
        btWrap_q   <= btWrap_d;
      end
    end
  end

  assign bt_valid = btValid_q;
  assign BT       = btTarget_q;
  assign bt_wrap  = btWrap_q;

  // -------------------------------------------------------------------------
  // Branch target buffer
  // -------------------------------------------------------------------------
`ifdef BTU_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W;

  logic [BTB_DEPTH-1:0] entryValid_q, entryValid_d;
  logic [TAG_W-1:0]     entryTag_q    [BTB_DEPTH];
  logic [PC_W-1:0]      entryTarget_q [BTB_DEPTH];

  logic [IDX_W-1:0] lookupIdx;
  logic [TAG_W-1:0] lookupTag;
  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             lookupHit;
  logic             predHit_q, predHit_d;
  logic [PC_W-1:0]  predTarget_q, predTarget_d;

  assign lookupIdx = lookup_pc[IDX_W-1:0];
  assign lookupTag = lookup_pc[PC_W-1:IDX_W];
  assign updIdx    = upd_pc[IDX_W-1:0];
  assign updTag    = upd_pc[PC_W-1:IDX_W];

  // Lookup reads the current (pre-update) array contents, which gives
  // read-before-write when lookup and update hit the same index.
  always_comb begin
    lookupHit    = entryValid_q[lookupIdx] && (entryTag_q[lookupIdx] == lookupTag);
    predHit_d    = lookupHit;
    predTarget_d = lookupHit ? entryTarget_q[lookupIdx] : '0;
  end

  // A taken branch claims its slot unconditionally; a not-taken branch only
  // evicts the slot if it is the current occupant.
  always_comb begin
    entryValid_d = entryValid_q;
    if (upd_valid) begin
      if (upd_taken) begin
        entryValid_d[updIdx] = 1'b1;
      end else if (entryTag_q[updIdx] == updTag) begin
        entryValid_d[updIdx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entryValid_q <= '0;
      predHit_q    <= 1'b0;
      predTarget_q <= '0;
    end else begin
      entryValid_q <= entryValid_d;
      predHit_q    <= predHit_d;
      predTarget_q <= predTarget_d;
    end
  end

  // Tags and targets are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      entryTag_q[updIdx]    <= updTag;
      entryTarget_q[updIdx] <= upd_target;
    end
  end

  assign pred_hit    = predHit_q;
  assign pred_target = predTarget_q;
`else
  logic                         unusedBtbInputs;
  logic [$clog2(BTB_DEPTH)-1:0] unusedIdx;

  assign unusedBtbInputs = ^{lookup_pc, upd_valid, upd_pc, upd_target, upd_taken};
  assign unusedIdx       = lookup_pc[$clog2(BTB_DEPTH)-1:0];

  assign pred_hit    = 1'b0;
  assign pred_target = '0;
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_target_unit
//
// Directed testbench for branch_target_unit with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, so every sample reflects the edge just taken. BTB scenarios are built
// when BTU_BTB_EN is defined; otherwise the tied-off prediction outputs are
// checked instead.
// ---------------------------------------------------------------------------
module tb_branch_target_unit;

  localparam int PC_W  = 8;
  localparam int IMM_W = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  immediate;
  logic [PC_W-1:0]   program_counter;
  logic              bt_valid;
  logic              bt_ready;
  logic [PC_W-1:0]   BT;
  logic              bt_wrap;
  logic [PC_W-1:0]   lookup_pc;
  logic              pred_hit;
  logic [PC_W-1:0]   pred_target;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic [PC_W-1:0]   upd_target;
  logic              upd_taken;

  int checks;
  int errors;

  branch_target_unit #(
    .PC_W      (PC_W),
    .IMM_W     (IMM_W),
    .BTB_DEPTH (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .immediate       (immediate),
    .program_counter (program_counter),
    .bt_valid        (bt_valid),
    .bt_ready        (bt_ready),
    .BT              (BT),
    .bt_wrap         (bt_wrap),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target),
    .upd_taken       (upd_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset with junk on the inputs, check reset values, then release.
  task automatic test_reset();
    rst_n           = 1'b0;
    in_valid        = 1'b1;
    immediate       = 16'h0005;
    program_counter = 8'h10;
    bt_ready        = 1'b1;
    lookup_pc       = 8'h23;
    upd_valid       = 1'b1;
    upd_pc          = 8'h23;
    upd_target      = 8'h40;
    upd_taken       = 1'b1;
    step();
    step();
    checks++;
    if (bt_valid !== 1'b0 || BT !== 8'h00 || bt_wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_bt: valid=%b BT=%h wrap=%b, expected 0/00/0", bt_valid, BT, bt_wrap);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_pred: hit=%b target=%h expected 0/00", pred_hit, pred_target);
    end
    in_valid  = 1'b0;
    upd_valid = 1'b0;
    upd_taken = 1'b0;
    lookup_pc = 8'h00;
    rst_n     = 1'b1;
    step();
  endtask

  // One plain addition, then drain.
  task automatic test_basic_add();
    program_counter = 8'h10;
    immediate       = 16'h0005;
    in_valid        = 1'b1;
    bt_ready        = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (bt_valid !== 1'b1 || BT !== 8'h15 || bt_wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_add: valid=%b BT=%h wrap=%b, expected 1/15/0", bt_valid, BT, bt_wrap);
    end
    step();
    checks++;
    if (bt_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_drain: bt_valid=%b expected 0", bt_valid);
    end
  endtask

  // Wrap boundaries, streamed one per cycle with bt_ready high.
  task automatic test_wrap();
    logic [PC_W-1:0]  pcs  [6] = '{8'h02, 8'hFE, 8'h05, 8'hFF, 8'h00, 8'h80};
    logic [IMM_W-1:0] imms [6] = '{16'hFFFD, 16'h0003, 16'hFFFB, 16'h0000, 16'h7FFF, 16'h8000};
    logic [PC_W-1:0]  expT [6] = '{8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h80};
    logic             expW [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      program_counter = pcs[i];
      immediate       = imms[i];
      in_valid        = 1'b1;
      step();
      checks++;
      if (bt_valid !== 1'b1 || BT !== expT[i] || bt_wrap !== expW[i]) begin
        errors++;
        $display("[TB] FAIL wrap_%0d: valid=%b BT=%h wrap=%b, expected 1/%h/%b",
                 i, bt_valid, BT, bt_wrap, expT[i], expW[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  // Stall the consumer for three cycles with a new request waiting.
  task automatic test_backpressure();
    program_counter = 8'h10;
    immediate       = 16'h0005;
    in_valid        = 1'b1;
    bt_ready        = 1'b1;
    step();
    program_counter = 8'h20;
    immediate       = 16'h0001;
    bt_ready        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || bt_valid !== 1'b1 || BT !== 8'h15 || bt_wrap !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_%0d: in_ready=%b valid=%b BT=%h wrap=%b, expected 0/1/15/0",
                 i, in_ready, bt_valid, BT, bt_wrap);
      end
      step();
    end
    bt_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    step();
    checks++;
    if (bt_valid !== 1'b1 || BT !== 8'h21) begin
      errors++;
      $display("[TB] FAIL stall_release_result: valid=%b BT=%h, expected 1/21", bt_valid, BT);
    end
  endtask

  // Continues from the backpressure task: results follow with no bubble.
  task automatic test_back_to_back();
    program_counter = 8'h30;
    immediate       = 16'h0002;
    step();
    checks++;
    if (bt_valid !== 1'b1 || BT !== 8'h32) begin
      errors++;
      $display("[TB] FAIL b2b_0: valid=%b BT=%h, expected 1/32", bt_valid, BT);
    end
    program_counter = 8'h40;
    immediate       = 16'hFFF0;
    step();
    checks++;
    if (bt_valid !== 1'b1 || BT !== 8'h30 || bt_wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_1: valid=%b BT=%h wrap=%b, expected 1/30/0", bt_valid, BT, bt_wrap);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (bt_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: bt_valid=%b expected 0", bt_valid);
    end
  endtask

`ifdef BTU_BTB_EN
  // Insert, alias, tag-guarded invalidate and read-before-write.
  task automatic test_btb();
    upd_valid  = 1'b1;
    upd_pc     = 8'h23;
    upd_target = 8'h40;
    upd_taken  = 1'b1;
    step();
    upd_valid = 1'b0;
    lookup_pc = 8'h23;
    step();
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 8'h40) begin
      errors++;
      $display("[TB] FAIL btb_hit: hit=%b target=%h, expected 1/40", pred_hit, pred_target);
    end
    lookup_pc = 8'h2B;
    step();
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 8'h00) begin
      errors++;
      $display("[TB] FAIL btb_alias: hit=%b target=%h, expected 0/00", pred_hit, pred_target);
    end
    // Not-taken from the aliasing PC must leave the occupant alone.
    upd_valid = 1'b1;
    upd_pc    = 8'h2B;
    upd_taken = 1'b0;
    step();
    upd_valid = 1'b0;
    lookup_pc = 8'h23;
    step();
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 8'h40) begin
      errors++;
      $display("[TB] FAIL btb_alias_keep: hit=%b target=%h, expected 1/40", pred_hit, pred_target);
    end
    upd_valid = 1'b1;
    upd_pc    = 8'h23;
    upd_taken = 1'b0;
    step();
    upd_valid = 1'b0;
    step();
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 8'h00) begin
      errors++;
      $display("[TB] FAIL btb_invalidate: hit=%b target=%h, expected 0/00", pred_hit, pred_target);
    end
    // Lookup and taken update of the same, empty entry in one cycle.
    lookup_pc  = 8'h23;
    upd_valid  = 1'b1;
    upd_pc     = 8'h23;
    upd_target = 8'h55;
    upd_taken  = 1'b1;
    step();
    upd_valid = 1'b0;
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL btb_rbw_same: hit=%b expected 0", pred_hit);
    end
    step();
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 8'h55) begin
      errors++;
      $display("[TB] FAIL btb_rbw_repeat: hit=%b target=%h, expected 1/55", pred_hit, pred_target);
    end
  endtask
`else
  // Without the BTB, updates and lookups never produce a prediction.
  task automatic test_btb();
    lookup_pc  = 8'h23;
    upd_valid  = 1'b1;
    upd_pc     = 8'h23;
    upd_target = 8'h40;
    upd_taken  = 1'b1;
    step();
    upd_valid = 1'b0;
    step();
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 8'h00) begin
      errors++;
      $display("[TB] FAIL btb_disabled: hit=%b target=%h, expected 0/00", pred_hit, pred_target);
    end
  endtask
`endif

  // Reset with a result pending and the BTB populated.
  task automatic test_midstream_reset();
    lookup_pc       = 8'h23;
    program_counter = 8'h10;
    immediate       = 16'hFFFD;
    in_valid        = 1'b1;
    bt_ready        = 1'b0;
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (bt_valid !== 1'b0 || BT !== 8'h00 || bt_wrap !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_bt: valid=%b BT=%h wrap=%b in_ready=%b, expected 0/00/0/1",
               bt_valid, BT, bt_wrap, in_ready);
    end
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_pred: hit=%b target=%h, expected 0/00", pred_hit, pred_target);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (pred_hit !== 1'b0 || bt_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL postreset_fresh: hit=%b valid=%b, expected 0/0", pred_hit, bt_valid);
    end
    program_counter = 8'h40;
    immediate       = 16'hFFFF;
    in_valid        = 1'b1;
    bt_ready        = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (bt_valid !== 1'b1 || BT !== 8'h3F || bt_wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL postreset_calc: valid=%b BT=%h wrap=%b, expected 1/3F/0", bt_valid, BT, bt_wrap);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] starting branch_target_unit directed tests");
    test_reset();
    test_basic_add();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_btb();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
